crc_unit: RTL and testbench
===========================

# crc_unit

Parametrised serial CRC engine for the tag datapath, generalising the fixed CRC-16 checker. Its CRC register is exposed as a parallel output.
- **Check mode:** the register accumulates a received bit stream (Select and access commands: Req_RN, Read, Write, sensor data) and flags pass/fail against a residue.
- **Generate mode:** the engine computes the CRC over outgoing reply bits, then shifts the (optionally inverted) CRC out serially for the tag encoder.

One instance per use: CRC-16 for access commands and replies, CRC-5 for Query.

## Interface
Parameters:
- `WIDTH`, 16: CRC length in bits (5 for Gen2 CRC-5).
- `POLY`, 16'h1021: polynomial without the x^WIDTH term (5'h09 for CRC-5).
- `PRESET`, 16'hFFFF: register value after reset/clear (5'b01001 for CRC-5).
- `RESIDUE`, 16'h1D0F: register value that means a good frame in check mode (5'h00 for CRC-5).
- `INVERT_OUT`, 1: when 1, generate mode shifts out ~crc (0 for CRC-5).
- `CNTW`, 10: bit-counter width.

Ports:
- `crcinclk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `clear`  in  1  synchronous preset; returns the block to IDLE.
- `mode`  in  1  0 = check, 1 = generate; sampled on the first accepted bit of a frame.
- `bitvalid`  in  1  `crcbitin` is valid this cycle.
- `crcbitin`  in  1  serial data bit, MSB first.
- `endframe`  in  1  single-cycle pulse marking the end of the frame.
- `crc`  out  WIDTH  current register contents.
- `crcok`  out  1  check-mode result; valid while `done` is high.
- `done`  out  1  frame finished (check result ready, or shift-out complete).
- `crcbitout`  out  1  serial CRC bit in generate mode.
- `outvalid`  out  1  `crcbitout` is valid this cycle.
- `bitcount`  out  CNTW  number of data bits accepted in this frame (saturating).
- `overflow`  out  1  sticky; set when `bitcount` saturates.

## Operation
- **Register update** on every accepted bit:
  - fb = `crcbitin` ^ crc[WIDTH-1];
  - crc <= {crc[WIDTH-2:0], 0} ^ (fb ? `POLY` : 0).
  - With defaults this is bit-identical to the existing CRC-16 checker.
- **FSM states:** IDLE, ACCUM, SHIFT, DONE.
  - **IDLE:** crc = `PRESET`. A `bitvalid` bit is accepted, `mode` is latched, and the FSM goes to ACCUM.
  - **ACCUM:** each `bitvalid` bit is accepted and `bitcount` increments.
    - `endframe` with latched mode 0: go to DONE; `crcok` <= (next crc == `RESIDUE`).
    - `endframe` with latched mode 1: go to SHIFT; the shift index is loaded with WIDTH-1.
  - **SHIFT:** `outvalid`=1 and `crcbitout` = crc[WIDTH-1] ^ `INVERT_OUT`.
    - crc shifts left, filling with 0; the index decrements.
    - After WIDTH output bits the FSM goes to DONE.
    - `bitvalid` is ignored.
  - **DONE:** `done`=1; `crcok` and `crc` are held. `bitvalid` and `endframe` are ignored. Only `clear` or `reset` leave this state.
- **Priority:** `reset` > `clear` > everything else. `clear` in any state forces crc=`PRESET`, IDLE, `bitcount`=0, `overflow`=0, `crcok`=0.
- **`endframe` and `bitvalid` in the same ACCUM cycle:** the bit is accepted first, and the result reflects the updated register.
- **`endframe` in IDLE** (empty frame): check mode goes to DONE with `crcok` = (`PRESET` == `RESIDUE`); generate mode shifts out the preset.
- **`bitcount` saturation:** `bitcount` saturates at 2^CNTW-1 and `overflow` latches. CRC accumulation continues regardless.
- **Reset mid-frame** in any state: the block returns to IDLE immediately, with no partial output.

## Timing
- **Reset values:** crc=`PRESET`, `crcok`=0, `done`=0, `crcbitout`=0, `outvalid`=0, `bitcount`=0, `overflow`=0, state IDLE.
- `crc` reflects a bit one cycle after the bit is accepted.
- **Check latency:** `done` and `crcok` rise on the edge that samples `endframe`, so they are visible the next cycle.
- **Generate latency:** the first `outvalid` cycle immediately follows the `endframe` cycle. `outvalid` is high for exactly WIDTH consecutive cycles, and `done` rises the cycle after the last output bit.
- Every output is registered; no combinational path from input to output.

## Structure
- **Package `crc_pkg`:** FSM state enum, plus Gen2 constants for both configurations:
  - CRC16_POLY / CRC16_PRESET / CRC16_RESIDUE;
  - CRC5_POLY / CRC5_PRESET / CRC5_RESIDUE.
- **Sub-module `crc_lfsr_step`:** purely combinational next-state function (crc, bit → next crc), parametrised by `WIDTH`/`POLY`. It is shared by ACCUM and by the residue compare.

## Test plan
- **Known-answer check, defaults:** generate mode, ASCII "123456789" MSB-first (72 bits), then `endframe` → `crc` reads 16'h29B1 before shift-out; `crcbitout` stream = 16'hD64E MSB-first over 16 `outvalid` cycles; then `done`=1.
- **Check pass:** check mode, the same 72 bits followed by 16'hD64E, then `endframe` → `crc`=16'h1D0F, `crcok`=1, `bitcount`=88. Flip any one bit → `crcok`=0.
- **CRC-5 (WIDTH=5, POLY=5'h09, PRESET=5'b01001, INVERT_OUT=0):** generate over a 17-bit Query body, then check the body plus the emitted 5 bits → `crcok`=1, crc=5'h00.
- **Simultaneous `bitvalid` + `endframe`:** the last bit arrives in the `endframe` cycle → result identical to the separate-cycle case.
- **`clear` and `reset` mid-SHIFT:** after 3 output bits, assert `clear` → next cycle `outvalid`=0, crc=16'hFFFF, IDLE. Repeat with async `reset` between clock edges → outputs reset immediately.
- **Saturation (CNTW=4):** feed 20 bits → `bitcount`=15, `overflow`=1, crc still matches the reference model; `clear` drops `overflow` to 0.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and Gen2 CRC constants for the serial CRC engine.
package crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } crc_state_e;

   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

   localparam logic [4:0]  CRC5_POLY     = 5'h09;
   localparam logic [4:0]  CRC5_PRESET   = 5'b01001;
   localparam logic [4:0]  CRC5_RESIDUE  = 5'h00;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit MSB-first LFSR step: next CRC register value for a single input bit.
module crc_lfsr_step #(
   parameter int unsigned       WIDTH = 16,
   parameter logic [WIDTH-1:0]  POLY  = 16'h1021
) (
   input  logic [WIDTH-1:0] crc_in,
   input  logic             bit_in,
   output logic [WIDTH-1:0] crc_out
);

   logic fb;

   // Feedback taps the register MSB against the incoming bit.
   always_comb begin
      fb      = bit_in ^ crc_in[WIDTH-1];
      crc_out = {crc_in[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
   end

endmodule

// File: rtl/crc_unit.sv
// Serial CRC engine: accumulates/checks a received stream or generates and
// shifts out the CRC of an outgoing stream.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | register at preset, waiting for the first bit of a frame
//   ST_ACCUM | accepting data bits, waiting for endframe
//   ST_SHIFT | generate mode: shifting the CRC out MSB first
//   ST_DONE  | result held until clear or reset
module crc_unit
   import crc_pkg::*;
#(
   parameter int unsigned       WIDTH      = 16,
   parameter logic [WIDTH-1:0]  POLY       = CRC16_POLY,
   parameter logic [WIDTH-1:0]  PRESET     = CRC16_PRESET,
   parameter logic [WIDTH-1:0]  RESIDUE    = CRC16_RESIDUE,
   parameter bit                INVERT_OUT = 1'b1,
   parameter int unsigned       CNTW       = 10
) (
   input  logic             crcinclk,
   input  logic             reset,
   input  logic             clear,
   input  logic             mode,
   input  logic             bitvalid,
   input  logic             crcbitin,
   input  logic             endframe,
   output logic [WIDTH-1:0] crc,
   output logic             crcok,
   output logic             done,
   output logic             crcbitout,
   output logic             outvalid,
   output logic [CNTW-1:0]  bitcount,
   output logic             overflow
);

   localparam int unsigned IDXW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   crc_state_e       state_q, state_d;
   logic [WIDTH-1:0] crc_q, crc_d;
   logic             crcok_q, crcok_d;
   logic             done_q, done_d;
   logic             crcbitout_q, crcbitout_d;
   logic             outvalid_q, outvalid_d;
   logic [CNTW-1:0]  bitcount_q, bitcount_d;
   logic             overflow_q, overflow_d;
   logic             mode_q, mode_d;
   logic [IDXW-1:0]  idx_q, idx_d;

   logic [WIDTH-1:0] crc_step;
   logic [WIDTH-1:0] crc_acc;
   logic             accept;
   logic             eff_mode;

   crc_lfsr_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_step (
      .crc_in  (crc_q),
      .bit_in  (crcbitin),
      .crc_out (crc_step)
   );

   // Next-state and registered-output logic for the frame FSM.
   always_comb begin
      state_d     = state_q;
      crc_d       = crc_q;
      crcok_d     = crcok_q;
      done_d      = done_q;
      crcbitout_d = crcbitout_q;
      outvalid_d  = outvalid_q;
      bitcount_d  = bitcount_q;
      overflow_d  = overflow_q;
      mode_d      = mode_q;
      idx_d       = idx_q;

      accept   = bitvalid && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
      // A bit arriving with endframe is folded in before the result is taken.
      crc_acc  = accept ? crc_step : crc_q;
      // An empty frame has no latched mode yet, so use the live input.
      eff_mode = (state_q == ST_IDLE) ? mode : mode_q;

      if (clear) begin
         state_d     = ST_IDLE;
         crc_d       = PRESET;
         crcok_d     = 1'b0;
         done_d      = 1'b0;
         crcbitout_d = 1'b0;
         outvalid_d  = 1'b0;
         bitcount_d  = '0;
         overflow_d  = 1'b0;
         mode_d      = 1'b0;
         idx_d       = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (accept) begin
                  crc_d = crc_step;
                  if (bitcount_q == CNT_MAX) begin
                     overflow_d = 1'b1;
                  end else begin
                     bitcount_d = bitcount_q + 1'b1;
                  end
                  if (state_q == ST_IDLE) begin
                     mode_d  = mode;
                     state_d = ST_ACCUM;
                  end
               end
               if (endframe) begin
                  crc_d = crc_acc;
                  if (!eff_mode) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                     crcok_d = (crc_acc == RESIDUE);
                  end else begin
                     state_d     = ST_SHIFT;
                     outvalid_d  = 1'b1;
                     crcbitout_d = crc_acc[WIDTH-1] ^ INVERT_OUT;
                     idx_d       = IDXW'(WIDTH - 1);
                  end
               end
            end
            ST_SHIFT: begin
               crc_d = {crc_q[WIDTH-2:0], 1'b0};
               if (idx_q == '0) begin
                  state_d     = ST_DONE;
                  done_d      = 1'b1;
                  outvalid_d  = 1'b0;
                  crcbitout_d = 1'b0;
               end else begin
                  crcbitout_d = crc_q[WIDTH-2] ^ INVERT_OUT;
                  idx_d       = idx_q - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State and output registers; reset overrides everything asynchronously.
   always_ff @(posedge crcinclk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         crc_q       <= PRESET;
         crcok_q     <= 1'b0;
         done_q      <= 1'b0;
         crcbitout_q <= 1'b0;
         outvalid_q  <= 1'b0;
         bitcount_q  <= '0;
         overflow_q  <= 1'b0;
         mode_q      <= 1'b0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         crc_q       <= crc_d;
         crcok_q     <= crcok_d;
         done_q      <= done_d;
         crcbitout_q <= crcbitout_d;
         outvalid_q  <= outvalid_d;
         bitcount_q  <= bitcount_d;
         overflow_q  <= overflow_d;
         mode_q      <= mode_d;
         idx_q       <= idx_d;
      end
   end

   assign crc       = crc_q;
   assign crcok     = crcok_q;
   assign done      = done_q;
   assign crcbitout = crcbitout_q;
   assign outvalid  = outvalid_q;
   assign bitcount  = bitcount_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_crc_unit.sv
// Directed bench for crc_unit: CRC-16 known answers, CRC-5 round trip,
// clear/reset during shift-out and bit-counter saturation.
module tb_crc_unit;
   import crc_pkg::*;

   logic crcinclk = 1'b0;
   logic reset    = 1'b1;
   logic clear    = 1'b0;
   logic mode     = 1'b0;
   logic bitvalid = 1'b0;
   logic crcbitin = 1'b0;
   logic endframe = 1'b0;

   logic [15:0] crc16;
   logic        crcok16, done16, bo16, ov16, ovf16;
   logic [9:0]  cnt16;

   logic [4:0]  crc5;
   logic        crcok5, done5, bo5, ov5, ovf5;
   logic [9:0]  cnt5;

   logic [15:0] crcs;
   logic        crcoks, dones, bos, ovs, ovfs;
   logic [3:0]  cnts;

   int n_chk = 0;
   int n_err = 0;

   always #5 crcinclk = ~crcinclk;

   crc_unit u16 (
      .crcinclk (crcinclk), .reset (reset), .clear (clear), .mode (mode),
      .bitvalid (bitvalid), .crcbitin (crcbitin), .endframe (endframe),
      .crc (crc16), .crcok (crcok16), .done (done16), .crcbitout (bo16),
      .outvalid (ov16), .bitcount (cnt16), .overflow (ovf16)
   );

   crc_unit #(
      .WIDTH (5), .POLY (CRC5_POLY), .PRESET (CRC5_PRESET),
      .RESIDUE (CRC5_RESIDUE), .INVERT_OUT (1'b0), .CNTW (10)
   ) u5 (
      .crcinclk (crcinclk), .reset (reset), .clear (clear), .mode (mode),
      .bitvalid (bitvalid), .crcbitin (crcbitin), .endframe (endframe),
      .crc (crc5), .crcok (crcok5), .done (done5), .crcbitout (bo5),
      .outvalid (ov5), .bitcount (cnt5), .overflow (ovf5)
   );

   crc_unit #(.CNTW (4)) us (
      .crcinclk (crcinclk), .reset (reset), .clear (clear), .mode (mode),
      .bitvalid (bitvalid), .crcbitin (crcbitin), .endframe (endframe),
      .crc (crcs), .crcok (crcoks), .done (dones), .crcbitout (bos),
      .outvalid (ovs), .bitcount (cnts), .overflow (ovfs)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge crcinclk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic ef);
      bitvalid = 1'b1;
      crcbitin = b;
      endframe = ef;
      tick();
      bitvalid = 1'b0;
      endframe = 1'b0;
   endtask

   task automatic pulse_end();
      endframe = 1'b1;
      tick();
      endframe = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   function automatic logic [15:0] m16(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
   endfunction

   function automatic logic [4:0] m5(input logic [4:0] c, input logic b);
      return {c[3:0], 1'b0} ^ ((b ^ c[4]) ? 5'h09 : 5'h00);
   endfunction

   logic [71:0] msg;
   logic [87:0] frame;
   logic [16:0] query;
   logic [4:0]  exp5;
   logic [4:0]  got5;
   logic [15:0] got16;
   logic [15:0] ref16;
   logic [19:0] satpat;
   int          nvalid;

   initial begin
      msg    = "123456789";
      frame  = {msg, 16'hD64E};
      query  = 17'b1000_0001_0010_0110_1;
      satpat = 20'hA5C3E;

      // Reset values while reset is held
      #12;
      chk("rst_crc",      {16'h0, crc16}, 32'h0000FFFF);
      chk("rst_crcok",    {31'h0, crcok16}, 32'h0);
      chk("rst_done",     {31'h0, done16}, 32'h0);
      chk("rst_outvalid", {31'h0, ov16}, 32'h0);
      chk("rst_bitout",   {31'h0, bo16}, 32'h0);
      chk("rst_bitcount", {22'h0, cnt16}, 32'h0);
      chk("rst_overflow", {31'h0, ovf16}, 32'h0);
      chk("rst_crc5",     {27'h0, crc5}, 32'h09);
      reset = 1'b0;
      tick();

      // Generate mode known answer
      do_clear();
      mode = 1'b1;
      for (int i = 71; i >= 0; i--) send_bit(msg[i], 1'b0);
      pulse_end();
      chk("gen_crc_before_shift", {16'h0, crc16}, 32'h29B1);
      got16  = '0;
      nvalid = 0;
      for (int i = 0; i < 16; i++) begin
         if (ov16) begin
            nvalid++;
            got16 = {got16[14:0], bo16};
         end
         tick();
      end
      chk("gen_stream",      {16'h0, got16}, 32'hD64E);
      chk("gen_valid_count", nvalid, 32'd16);
      chk("gen_done",        {31'h0, done16}, 32'h1);
      chk("gen_outvalid_off", {31'h0, ov16}, 32'h0);

      // Check mode, good frame
      do_clear();
      mode = 1'b0;
      for (int i = 87; i >= 0; i--) send_bit(frame[i], 1'b0);
      pulse_end();
      chk("chk_crc",      {16'h0, crc16}, 32'h1D0F);
      chk("chk_crcok",    {31'h0, crcok16}, 32'h1);
      chk("chk_done",     {31'h0, done16}, 32'h1);
      chk("chk_bitcount", {22'h0, cnt16}, 32'd88);

      // DONE ignores further bits
      send_bit(1'b1, 1'b1);
      chk("done_hold_crc", {16'h0, crc16}, 32'h1D0F);
      chk("done_hold_cnt", {22'h0, cnt16}, 32'd88);

      // Check mode, corrupted frame
      do_clear();
      frame[40] = ~frame[40];
      for (int i = 87; i >= 0; i--) send_bit(frame[i], 1'b0);
      pulse_end();
      chk("chk_bad_crcok", {31'h0, crcok16}, 32'h0);
      chk("chk_bad_done",  {31'h0, done16}, 32'h1);
      frame[40] = ~frame[40];

      // Last bit together with endframe
      do_clear();
      for (int i = 87; i >= 1; i--) send_bit(frame[i], 1'b0);
      send_bit(frame[0], 1'b1);
      chk("simul_crc",   {16'h0, crc16}, 32'h1D0F);
      chk("simul_crcok", {31'h0, crcok16}, 32'h1);
      chk("simul_cnt",   {22'h0, cnt16}, 32'd88);

      // Empty frame in check mode
      do_clear();
      pulse_end();
      chk("empty_done",  {31'h0, done16}, 32'h1);
      chk("empty_crcok", {31'h0, crcok16}, 32'h0);

      // CRC-5 generate then check
      exp5 = 5'b01001;
      for (int i = 16; i >= 0; i--) exp5 = m5(exp5, query[i]);
      do_clear();
      mode = 1'b1;
      for (int i = 16; i >= 0; i--) send_bit(query[i], 1'b0);
      pulse_end();
      chk("crc5_gen_reg", {27'h0, crc5}, {27'h0, exp5});
      got5   = '0;
      nvalid = 0;
      for (int i = 0; i < 5; i++) begin
         if (ov5) begin
            nvalid++;
            got5 = {got5[3:0], bo5};
         end
         tick();
      end
      chk("crc5_stream", {27'h0, got5}, {27'h0, exp5});
      chk("crc5_valid",  nvalid, 32'd5);
      chk("crc5_done",   {31'h0, done5}, 32'h1);
      do_clear();
      mode = 1'b0;
      for (int i = 16; i >= 0; i--) send_bit(query[i], 1'b0);
      for (int i = 4; i >= 0; i--) send_bit(exp5[i], 1'b0);
      pulse_end();
      chk("crc5_chk_ok",  {31'h0, crcok5}, 32'h1);
      chk("crc5_chk_crc", {27'h0, crc5}, 32'h0);

      // Clear during shift-out
      do_clear();
      mode = 1'b1;
      for (int i = 71; i >= 64; i--) send_bit(msg[i], 1'b0);
      pulse_end();
      tick();
      tick();
      tick();
      do_clear();
      chk("clr_outvalid", {31'h0, ov16}, 32'h0);
      chk("clr_crc",      {16'h0, crc16}, 32'hFFFF);
      chk("clr_done",     {31'h0, done16}, 32'h0);
      chk("clr_cnt",      {22'h0, cnt16}, 32'h0);
      send_bit(1'b0, 1'b0);
      chk("clr_idle_accept", {22'h0, cnt16}, 32'd1);

      // Asynchronous reset during shift-out
      do_clear();
      for (int i = 71; i >= 64; i--) send_bit(msg[i], 1'b0);
      pulse_end();
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("arst_outvalid", {31'h0, ov16}, 32'h0);
      chk("arst_crc",      {16'h0, crc16}, 32'hFFFF);
      chk("arst_bitout",   {31'h0, bo16}, 32'h0);
      chk("arst_cnt",      {22'h0, cnt16}, 32'h0);
      #1;
      reset = 1'b0;
      tick();

      // Bit-counter saturation with a 4-bit counter
      do_clear();
      mode  = 1'b0;
      ref16 = 16'hFFFF;
      for (int i = 19; i >= 0; i--) begin
         ref16 = m16(ref16, satpat[i]);
         send_bit(satpat[i], 1'b0);
      end
      chk("sat_cnt",      {28'h0, cnts}, 32'd15);
      chk("sat_overflow", {31'h0, ovfs}, 32'h1);
      chk("sat_crc",      {16'h0, crcs}, {16'h0, ref16});
      do_clear();
      chk("sat_clr_overflow", {31'h0, ovfs}, 32'h0);
      chk("sat_clr_cnt",      {28'h0, cnts}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
